spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI target (responder) that sits on the far end of one of the PL SPI master links (CSN/SCK/SDI/SDO) and emulates a peripheral register map.
- Used as an on-chip loopback target and as a bench model for the ADC/FDA/DAC/LPL serial masters.
- Oversamples the serial lines in the clk125 domain, decodes 16-bit command frames, and holds a 16 x 8 register bank.
- Reports host-visible write strobes and frame errors.

Parameters:
- DW, 8, data field width in bits.
- AW, 7, address field width in bits.
- NREG, 16, number of implemented registers; only addresses 0..NREG-1 are decoded.
- RST_VAL, 8'h00, reset value of every bank register.

Ports:
- clk125  input  1  system clock, 125 MHz.
- rst  input  1  synchronous, active-high reset.
- SPI_CSN  input  1  chip select from master, active low, asynchronous to clk125.
- SPI_SCK  input  1  serial clock from master, mode 0 (CPOL=0, CPHA=0), at most clk125/8.
- SPI_SDI  input  1  master-to-target data, MSB first.
- SPI_SDO  output  1  target-to-master data, MSB first.
- host_addr  input  4  parallel read address into the bank.
- host_rdata  output  DW  registered bank[host_addr]; 1-cycle latency.
- wr_stb  output  1  one-cycle pulse when a serial write commits.
- wr_addr  output  AW  address of the last committed write.
- wr_data  output  DW  data of the last committed write.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- busy  output  1  high while a frame is in progress (synchronized CSN low).

Behaviour:
- Synchronization:
  - SPI_CSN, SPI_SCK and SPI_SDI each pass through a 2-FF synchronizer.
  - Synchronizer reset values: CSN = 1, SCK = 0, SDI = 0.
  - A third register on SCK provides edge detection: rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
- Frame format, 16 bits MSB first:
  - bit15: R/W (1 = read).
  - bits14:8: address.
  - bits7:0: data (write) or don't-care (read).
- States:
  - IDLE: wait for synchronized CSN = 0 → CMD, bit_cnt = 0.
  - CMD: on each rise, shift SDI into cmd_sr and increment bit_cnt. At bit_cnt = 8, latch R/W and address → DATA. For a read, load tx_sr with bank[addr[3:0]]; load 0x00 instead if addr >= NREG.
  - DATA: on each rise, shift SDI into data_sr and increment bit_cnt. On each fall while bit_cnt is 8..15, drive SPI_SDO = tx_sr[7] and shift tx_sr left. The first fall after rise 8 presents the data MSB.
  - CSN rise in CMD or DATA → CHECK.
  - CHECK (1 cycle):
    - If bit_cnt == 16 and the frame is a write: commit bank[addr] = data_sr; pulse wr_stb; update wr_addr/wr_data. Addresses >= NREG still pulse wr_stb but leave the bank unchanged.
    - If bit_cnt == 16 and the frame is a read: no side effects.
    - If bit_cnt != 16: pulse frame_err, no write.
    - Then → IDLE.
  - bit_cnt saturates at 17. More than 16 rises therefore yields frame_err.
- SPI_SDO:
  - 0 whenever the state is not DATA. No tristate.
  - Holds its last value between falls.
  - Registered output.
- busy = (state != IDLE) & (state != WAIT_HI).
- Latency:
  - CSN rise at the pins → wr_stb high 4 clk125 cycles later: 2 sync + 1 edge + 1 CHECK.
  - host_rdata reflects a committed write on the cycle after wr_stb.
- Simultaneous events:
  - A CSN rise coinciding with a SCK rise in the same synchronized sample: the SCK rise is counted first, then CHECK.
  - A host_addr read of the register being committed returns the old value that cycle and the new value on the next.
- Reset:
  - Effect: all outputs 0; bank = RST_VAL; wr_addr = 0, wr_data = 0; state → WAIT_HI.
  - WAIT_HI: wait for synchronized CSN = 1, then → IDLE. A frame already in progress when rst is applied is ignored entirely, with no frame_err.
- No reaction to SCK edges while CSN is high.

Test Plan:
- Write 0x05 ← 0xA5: frame 0x05A5 at SCK = 10 MHz, then CSN high → wr_stb one pulse, wr_addr = 0x05, wr_data = 0xA5; host_addr = 5 gives host_rdata = 0xA5; frame_err stays 0.
- Read-back: after the write above, frame 0x8500 → SDO bits on master rises 9..16 = 1,0,1,0,0,1,0,1; no wr_stb; bank unchanged.
- Out-of-range: write frame 0x30FF → wr_stb pulses with wr_addr = 0x30, bank unchanged. Read frame 0xB000 → SDO = 0x00.
- Short and long frames: 12 SCK cycles then CSN high → frame_err pulse, no write. 17 SCK cycles on write frame 0x0311 → frame_err, bank[3] unchanged.
- Reset mid-frame: assert rst after 6 SCK rises, release while CSN is still low, finish the frame → no wr_stb, no frame_err. The next full frame 0x0177 commits normally.
- Back-to-back: frames 0x0211 and 0x0322 separated by 4 clk125 cycles of CSN high → two wr_stb pulses; bank[2] = 0x11, bank[3] = 0x22.

Source files
------------

// File: rtl/spi_reg_responder.sv
// spi_reg_responder
//   SPI mode-0 target emulating a 16 x 8 peripheral register bank. The serial
//   lines are oversampled in the clk125 domain. 16-bit frames are decoded:
//   R/W bit, 7-bit address, then 8 data bits, all MSB first.
//
// Ports
//   clk125, rst        system clock; synchronous active-high reset
//   SPI_CSN/SCK/SDI    serial inputs from the master (asynchronous)
//   SPI_SDO            registered serial read data, MSB first
//   host_addr          parallel read address into the bank
//   host_rdata         registered bank[host_addr], 1-cycle latency
//   wr_stb             1-cycle pulse when a serial write commits
//   wr_addr, wr_data   address/data of the last committed write
//   frame_err          1-cycle pulse on a frame that is not exactly 16 bits
//   busy               frame in progress
//
// state   | meaning
// --------+---------------------------------------------------------------
// WAIT_HI | after reset; wait for CSN high so a partial frame is ignored
// IDLE    | CSN high; wait for CSN low
// CMD     | shifting R/W + address bits
// DATA    | shifting data bits in, read data out on SCK falls
// CHECK   | one cycle; commit the write or flag a frame error

module spi_reg_responder #(
  parameter int             DW      = 8,
  parameter int             AW      = 7,
  parameter int             NREG    = 16,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk125,
  input  logic          rst,
  input  logic          SPI_CSN,
  input  logic          SPI_SCK,
  input  logic          SPI_SDI,
  output logic          SPI_SDO,
  input  logic [3:0]    host_addr,
  output logic [DW-1:0] host_rdata,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_err,
  output logic          busy
);

  localparam int CMD_BITS   = 1 + AW;
  localparam int FRAME_BITS = 1 + AW + DW;
  localparam int CW         = $clog2(FRAME_BITS + 2);
  localparam int IW         = $clog2(NREG);

  localparam logic [CW-1:0] CNT_CMD_LAST = CW'(CMD_BITS - 1);
  localparam logic [CW-1:0] CNT_CMD      = CW'(CMD_BITS);
  localparam logic [CW-1:0] CNT_FRAME    = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT      = CW'(FRAME_BITS + 1);
  localparam logic [AW-1:0] NREG_A       = AW'(NREG);

  typedef enum logic [2:0] {
    S_WAIT_HI,
    S_IDLE,
    S_CMD,
    S_DATA,
    S_CHECK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_csn_s1, r_csn_s;
  logic r_sck_s1, r_sck_s, r_sck_d;
  logic r_sdi_s1, r_sdi_s;
  logic [1:0] r_sync_vld;

  logic [CW-1:0] r_bit_cnt;
  logic [AW-1:0] r_cmd_sr;
  logic [DW-1:0] r_data_sr;
  logic [DW-1:0] r_tx_sr;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic          r_sdo;
  logic          r_wr_stb;
  logic          r_frame_err;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_host_rdata;
  logic [DW-1:0] r_bank [NREG];

  logic            w_sck_rise;
  logic            w_sck_fall;
  logic [AW:0]     w_cmd_nxt;
  logic            w_tx_window;

  assign w_sck_rise  = r_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s & r_sck_d;
  // Command byte as it stands once the current SDI sample is shifted in.
  assign w_cmd_nxt   = {r_cmd_sr, r_sdi_s};
  assign w_tx_window = (r_bit_cnt >= CNT_CMD) && (r_bit_cnt < CNT_FRAME);

  // Input synchronizers. r_sync_vld marks when r_csn_s has really sampled
  // the pin after reset, so WAIT_HI does not trust the reset value of CSN.
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_csn_s1   <= 1'b1;
      r_csn_s    <= 1'b1;
      r_sck_s1   <= 1'b0;
      r_sck_s    <= 1'b0;
      r_sck_d    <= 1'b0;
      r_sdi_s1   <= 1'b0;
      r_sdi_s    <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_csn_s1   <= SPI_CSN;
      r_csn_s    <= r_csn_s1;
      r_sck_s1   <= SPI_SCK;
      r_sck_s    <= r_sck_s1;
      r_sck_d    <= r_sck_s;
      r_sdi_s1   <= SPI_SDI;
      r_sdi_s    <= r_sdi_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) r_state <= S_WAIT_HI;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_HI: if (r_sync_vld[1] && r_csn_s) w_state_nxt = S_IDLE;
      S_IDLE:    if (!r_csn_s) w_state_nxt = S_CMD;
      S_CMD: begin
        if (r_csn_s)
          w_state_nxt = S_CHECK;
        else if (w_sck_rise && (r_bit_cnt == CNT_CMD_LAST))
          w_state_nxt = S_DATA;
      end
      S_DATA:    if (r_csn_s) w_state_nxt = S_CHECK;
      S_CHECK:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_WAIT_HI;
    endcase
  end

  // A SCK rise seen together with CSN high is still counted because the
  // shift logic below acts on the rise regardless of the state change.
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_cmd_sr     <= '0;
      r_data_sr    <= '0;
      r_tx_sr      <= '0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_sdo        <= 1'b0;
      r_wr_stb     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_host_rdata <= '0;
      for (int i = 0; i < NREG; i++) r_bank[i] <= RST_VAL;
    end else begin
      r_wr_stb     <= 1'b0;
      r_frame_err  <= 1'b0;
      // Sampled before any commit this cycle: a read of the register being
      // written returns the old value now and the new value next cycle.
      r_host_rdata <= r_bank[host_addr];
      if (r_state != S_DATA) r_sdo <= 1'b0;

      case (r_state)
        S_IDLE: r_bit_cnt <= '0;
        S_CMD: begin
          if (w_sck_rise) begin
            r_cmd_sr  <= w_cmd_nxt[AW-1:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == CNT_CMD_LAST) begin
              r_rw    <= w_cmd_nxt[AW];
              r_addr  <= w_cmd_nxt[AW-1:0];
              r_tx_sr <= (w_cmd_nxt[AW-1:0] < NREG_A) ?
                         r_bank[w_cmd_nxt[IW-1:0]] : '0;
            end
          end
        end
        S_DATA: begin
          if (w_sck_rise) begin
            r_data_sr <= {r_data_sr[DW-2:0], r_sdi_s};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_sck_fall && w_tx_window) begin
            r_sdo   <= r_tx_sr[DW-1];
            r_tx_sr <= {r_tx_sr[DW-2:0], 1'b0};
          end
        end
        S_CHECK: begin
          if (r_bit_cnt == CNT_FRAME) begin
            if (!r_rw) begin
              r_wr_stb  <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= r_data_sr;
              if (r_addr < NREG_A) r_bank[r_addr[IW-1:0]] <= r_data_sr;
            end
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SPI_SDO    = r_sdo;
  assign host_rdata = r_host_rdata;
  assign wr_stb     = r_wr_stb;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE) && (r_state != S_WAIT_HI);

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: a mode-0 SPI master model at 10 MHz, a bank
// model, and a scoreboard queue of expected wr_stb / frame_err events.

module tb_spi_reg_responder;

  localparam int HP = 50;

  logic       clk125 = 1'b0;
  logic       rst;
  logic       spi_csn, spi_sck, spi_sdi, spi_sdo;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         err;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        sb_q[$];
  logic [7:0] m_bank[16];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] rd_v;
  int         lat;

  always #4 clk125 = ~clk125;

  spi_reg_responder dut (
    .clk125     (clk125),
    .rst        (rst),
    .SPI_CSN    (spi_csn),
    .SPI_SCK    (spi_sck),
    .SPI_SDI    (spi_sdi),
    .SPI_SDO    (spi_sdo),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.err = 1'b0; e.addr = a; e.data = d;
    sb_q.push_back(e);
    if (a < 7'd16) m_bank[a[3:0]] = d;
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.addr = '0; e.data = '0;
    sb_q.push_back(e);
  endtask

  // One master transfer. rst_at >= 0 pulses rst after that many SCK rises.
  task automatic spi_xfer(input logic [15:0] word, input int nbits, input int rst_at,
                          input bit align, output logic [7:0] rd);
    logic [15:0] w;
    w  = word;
    rd = '0;
    if (align) begin
      @(negedge clk125);
      #1;
    end
    spi_csn = 1'b0;
    #HP;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #40;
        rst = 1'b0;
        #40;
        for (int k = 0; k < 16; k++) m_bank[k] = 8'h00;
      end
      spi_sdi = (i < 16) ? w[15-i] : 1'b0;
      #HP;
      spi_sck = 1'b1;
      if (i >= 8 && i < 16) rd = {rd[6:0], spi_sdo};
      if (i == 4) chk("busy_mid", busy, 1);
      #HP;
      spi_sck = 1'b0;
    end
    #HP;
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
  endtask

  task automatic host_rd(input logic [3:0] a);
    host_addr = a;
    @(negedge clk125);
    @(negedge clk125);
    chk($sformatf("bank[%0d]", a), host_rdata, m_bank[a]);
    #1;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk125);
    #1;
  endtask

  // Scoreboard consumer: every strobe or error pulse must match the head.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk125);
      if (wr_stb || frame_err) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexp", {wr_stb, frame_err}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          chk("ev_err", frame_err, e.err);
          chk("ev_stb", wr_stb, !e.err);
          if (!e.err) begin
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    spi_csn   = 1'b1;
    spi_sck   = 1'b0;
    spi_sdi   = 1'b0;
    host_addr = 4'd0;
    for (int k = 0; k < 16; k++) m_bank[k] = 8'h00;
    repeat (4) @(negedge clk125);
    rst = 1'b0;
    repeat (3) @(negedge clk125);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sdo", spi_sdo, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);

    // Write 0x05 <- 0xA5 with latency and read-during-commit checks.
    host_addr = 4'd5;
    push_wr(7'h05, 8'hA5);
    spi_xfer(16'h05A5, 16, -1, 1'b1, rd_v);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk125);
      #1;
      if (wr_stb) begin
        lat = c;
        break;
      end
    end
    chk("stb_latency", lat, 4);
    chk("rd_old", host_rdata, 8'h00);
    @(posedge clk125);
    #1;
    chk("rd_new", host_rdata, 8'hA5);
    settle();

    spi_xfer(16'h8500, 16, -1, 1'b1, rd_v);
    chk("sdo_rd05", rd_v, 8'hA5);
    settle();
    host_rd(4'd5);

    push_wr(7'h30, 8'hFF);
    spi_xfer(16'h30FF, 16, -1, 1'b1, rd_v);
    settle();
    host_rd(4'd0);
    spi_xfer(16'hB000, 16, -1, 1'b1, rd_v);
    chk("sdo_rd30", rd_v, 8'h00);
    settle();

    push_err();
    spi_xfer(16'h0455, 12, -1, 1'b1, rd_v);
    settle();
    host_rd(4'd4);
    push_err();
    spi_xfer(16'h0311, 17, -1, 1'b1, rd_v);
    settle();
    host_rd(4'd3);

    // Reset mid-frame: the remainder of that frame must be ignored.
    spi_xfer(16'h0499, 16, 6, 1'b1, rd_v);
    settle();
    chk("rst_mid_wr_addr", wr_addr, 0);
    host_rd(4'd5);
    push_wr(7'h01, 8'h77);
    spi_xfer(16'h0177, 16, -1, 1'b1, rd_v);
    settle();
    host_rd(4'd1);
    host_rd(4'd4);

    push_wr(7'h02, 8'h11);
    push_wr(7'h03, 8'h22);
    spi_xfer(16'h0211, 16, -1, 1'b1, rd_v);
    #32;
    spi_xfer(16'h0322, 16, -1, 1'b0, rd_v);
    settle();
    host_rd(4'd2);
    host_rd(4'd3);

    repeat (10) @(negedge clk125);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
